ex_unit_mc: RTL and testbench

EX_UNIT_MC -- requirements
Module: ex_unit_mc

---
 rtl/ex_pkg.sv | 39 +++
 rtl/ex_unit_mc_if.sv | 47 ++++
 rtl/ex_mul_iter.sv | 69 ++++++
 rtl/ex_unit_mc.sv | 194 +++++++++++++++++++
 tb/tb_ex_unit_mc.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/ex_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_pkg
//  Description : Shared definitions for the multi-cycle execute unit:
//                opcode encodings, FSM state encoding and the bit
//                positions of the {N,Z,C,V} flags inside psr_flags.
//  Revision    : 1.0  initial release
// ============================================================================
package ex_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_MOV = 4'd5,
        OP_LSL = 4'd6,
        OP_LSR = 4'd7,
        OP_ASR = 4'd8,
        OP_ROR = 4'd9,
        OP_MUL = 4'd10,
        OP_CMP = 4'd11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // psr_flags = {N,Z,C,V}
    localparam int c_flag_n = 3;
    localparam int c_flag_z = 2;
    localparam int c_flag_c = 1;
    localparam int c_flag_v = 0;

endpackage
`default_nettype wire

// File: rtl/ex_unit_mc_if.sv
`default_nettype none
// ============================================================================
//  Module      : ex_unit_mc_if
//  Description : Issue/result bundle of the execute unit.
//                master : operation source / result consumer
//                slave  : the execute unit
//  Ports       : in_valid/in_ready/op/src_a/src_b/imm/imm_sel/sh_amt/
//                psr_wen/dest (issue side), out_valid/out_ready/out_data/
//                out_dest/out_wr (result side), psr_flags, busy.
//  Revision    : 1.0  initial release
// ============================================================================
interface ex_unit_mc_if #(
    parameter int DATA_W = 32
);
    localparam int SH_W = $clog2(DATA_W);

    logic              in_valid;
    logic              in_ready;
    logic [3:0]        op;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic [DATA_W-1:0] imm;
    logic              imm_sel;
    logic [SH_W-1:0]   sh_amt;
    logic              psr_wen;
    logic [2:0]        dest;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [2:0]        out_dest;
    logic              out_wr;
    logic [3:0]        psr_flags;
    logic              busy;

    modport master (
        output in_valid, op, src_a, src_b, imm, imm_sel, sh_amt, psr_wen, dest,
        output out_ready,
        input  in_ready, out_valid, out_data, out_dest, out_wr, psr_flags, busy
    );

    modport slave (
        input  in_valid, op, src_a, src_b, imm, imm_sel, sh_amt, psr_wen, dest,
        input  out_ready,
        output in_ready, out_valid, out_data, out_dest, out_wr, psr_flags, busy
    );
endinterface
`default_nettype wire

// File: rtl/ex_mul_iter.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mul_iter
//  Description : Iterative unsigned shift-add multiplier retiring MUL_STEP
//                multiplier bits per cycle. i_start loads the operands;
//                o_done pulses for one cycle DATA_W/MUL_STEP+1 cycles after
//                i_start, with o_product holding the low DATA_W bits.
//  Ports       : clk, reset, i_start, i_a, i_b, o_done, o_product
//  Revision    : 1.0  initial release
// ============================================================================
module ex_mul_iter #(
    parameter int DATA_W   = 32,
    parameter int MUL_STEP = 2
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              i_start,
    input  wire logic [DATA_W-1:0] i_a,
    input  wire logic [DATA_W-1:0] i_b,
    output logic                   o_done,
    output logic [DATA_W-1:0]      o_product
);
    localparam int STEPS = DATA_W / MUL_STEP;
    localparam int CNT_W = $clog2(STEPS + 1);

    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0] r_mplier;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_active;
    logic              r_done;
    logic [DATA_W-1:0] w_partial;

    // Partial product of the multiplicand and the current multiplier digit.
    assign w_partial = r_mcand * {{(DATA_W-MUL_STEP){1'b0}}, r_mplier[MUL_STEP-1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else if (i_start) begin
            r_acc    <= '0;
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_cnt    <= '0;
            r_active <= 1'b1;
            r_done   <= 1'b0;
        end else if (r_active) begin
            r_acc    <= r_acc + w_partial;
            r_mcand  <= r_mcand << MUL_STEP;
            r_mplier <= r_mplier >> MUL_STEP;
            r_cnt    <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(STEPS - 1)) begin
                r_active <= 1'b0;
                r_done   <= 1'b1;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign o_done    = r_done;
    assign o_product = r_acc;
endmodule
`default_nettype wire

// File: rtl/ex_unit_mc.sv
`default_nettype none
// ============================================================================
//  Module      : ex_unit_mc
//  Description : Execute unit: single-cycle ALU/shifter plus iterative
//                multiplier, one registered result slot with valid/ready
//                output and registered {N,Z,C,V} flags.
//  Ports       : clk, reset (sync, active-high), bus (ex_unit_mc_if.slave)
//  Revision    : 1.0  initial release
// ============================================================================
module ex_unit_mc
    import ex_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int MUL_STEP = 2
) (
    input  wire logic   clk,
    input  wire logic   reset,
    ex_unit_mc_if.slave bus
);
    localparam int SH_W = $clog2(DATA_W);
    localparam int M    = DATA_W - 1;

    state_e            r_state;
    state_e            w_state_next;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [2:0]        r_out_dest;
    logic              r_out_wr;
    logic [3:0]        r_flags;
    logic [2:0]        r_mul_dest;
    logic              r_mul_psr_wen;

    logic              w_accept;
    logic              w_is_mul;
    logic              w_mul_start;
    logic              w_mul_done;
    logic              w_load_mul;
    logic [DATA_W-1:0] w_mul_product;

    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [SH_W-1:0]   w_sh;
    logic [DATA_W:0]   w_add;
    logic [DATA_W:0]   w_sub;
    logic [DATA_W:0]   w_lsl;
    logic [DATA_W:0]   w_lsr;
    logic [DATA_W:0]   w_asr;
    logic [2*DATA_W-1:0] w_ror;
    logic [DATA_W-1:0] w_res;
    logic [3:0]        w_flags;
    logic              w_wr;
    logic              w_flag_en;

    // The result slot itself absorbs output stalls while the FSM sits in
    // IDLE, so the cycle that drains the slot can also accept a new op.
    assign bus.in_ready  = (r_state == ST_IDLE) && (!r_out_valid || bus.out_ready);
    assign bus.busy      = (r_state == ST_MUL);
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_dest  = r_out_dest;
    assign bus.out_wr    = r_out_wr;
    assign bus.psr_flags = r_flags;

    assign w_accept    = bus.in_valid && bus.in_ready;
    assign w_is_mul    = (op_e'(bus.op) == OP_MUL);
    assign w_mul_start = w_accept && w_is_mul;
    assign w_load_mul  = (r_state == ST_MUL) && w_mul_done;

    ex_mul_iter #(
        .DATA_W   (DATA_W),
        .MUL_STEP (MUL_STEP)
    ) u_mul (
        .clk       (clk),
        .reset     (reset),
        .i_start   (w_mul_start),
        .i_a       (bus.src_a),
        .i_b       (w_b),
        .o_done    (w_mul_done),
        .o_product (w_mul_product)
    );

    // ---------------- single-cycle datapath ----------------
    assign w_a   = bus.src_a;
    assign w_b   = bus.imm_sel ? bus.imm : bus.src_b;
    assign w_sh  = bus.sh_amt;
    assign w_add = {1'b0, w_a} + {1'b0, w_b};
    assign w_sub = {1'b0, w_a} + {1'b0, ~w_b} + {{DATA_W{1'b0}}, 1'b1};
    // Carry-out guard bits sit just outside the shifted word.
    assign w_lsl = {1'b0, w_a} << w_sh;
    assign w_lsr = {w_a, 1'b0} >> w_sh;
    assign w_asr = $unsigned($signed({w_a, 1'b0}) >>> w_sh);
    assign w_ror = {w_a, w_a} >> w_sh;

    always_comb begin
        w_res     = w_b;
        w_flags   = r_flags;
        w_wr      = 1'b1;
        w_flag_en = 1'b1;
        case (op_e'(bus.op))
            OP_ADD: begin
                w_res              = w_add[M:0];
                w_flags[c_flag_c]  = w_add[DATA_W];
                w_flags[c_flag_v]  = (w_a[M] == w_b[M]) && (w_add[M] != w_a[M]);
            end
            OP_SUB, OP_CMP: begin
                w_res              = w_sub[M:0];
                w_flags[c_flag_c]  = w_sub[DATA_W];
                w_flags[c_flag_v]  = (w_a[M] != w_b[M]) && (w_sub[M] != w_a[M]);
                w_wr               = (op_e'(bus.op) != OP_CMP);
            end
            OP_AND: w_res = w_a & w_b;
            OP_OR:  w_res = w_a | w_b;
            OP_XOR: w_res = w_a ^ w_b;
            OP_MOV: w_res = w_b;
            OP_LSL: begin
                w_res = w_lsl[M:0];
                if (w_sh != '0) w_flags[c_flag_c] = w_lsl[DATA_W];
            end
            OP_LSR: begin
                w_res = w_lsr[DATA_W:1];
                if (w_sh != '0) w_flags[c_flag_c] = w_lsr[0];
            end
            OP_ASR: begin
                w_res = w_asr[DATA_W:1];
                if (w_sh != '0) w_flags[c_flag_c] = w_asr[0];
            end
            OP_ROR: begin
                w_res = w_ror[M:0];
                if (w_sh != '0) w_flags[c_flag_c] = w_ror[M];
            end
            default: begin
                // Unknown opcodes (and MUL, which never loads from here)
                // behave as a non-writing MOV without flag effects.
                w_res     = w_b;
                w_wr      = 1'b0;
                w_flag_en = 1'b0;
            end
        endcase
        w_flags[c_flag_n] = w_res[M];
        w_flags[c_flag_z] = (w_res == '0);
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_mul_start) w_state_next = ST_MUL;
            ST_MUL:  if (w_mul_done)  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ---------------- result slot and flags ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_dest    <= '0;
            r_out_wr      <= 1'b0;
            r_flags       <= '0;
            r_mul_dest    <= '0;
            r_mul_psr_wen <= 1'b0;
        end else begin
            if (w_accept && !w_is_mul) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_res;
                r_out_dest  <= bus.dest;
                r_out_wr    <= w_wr;
                if (bus.psr_wen && w_flag_en) r_flags <= w_flags;
            end else if (w_load_mul) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_mul_product;
                r_out_dest  <= r_mul_dest;
                r_out_wr    <= 1'b1;
                if (r_mul_psr_wen) begin
                    r_flags[c_flag_n] <= w_mul_product[M];
                    r_flags[c_flag_z] <= (w_mul_product == '0);
                end
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_mul_start) begin
                r_mul_dest    <= bus.dest;
                r_mul_psr_wen <= bus.psr_wen;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ex_unit_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_unit_mc
//  Description : Self-checking bench for ex_unit_mc (DATA_W=32, MUL_STEP=2):
//                table of single-cycle ops with hand-computed results and
//                flags, then multiply latency, output stall and reset-abort
//                sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ex_unit_mc;
    import ex_pkg::*;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic        imm_sel;
        logic [4:0]  sh;
        logic        wen;
        logic [2:0]  dest;
        logic [31:0] exp_data;
        logic        exp_wr;
        logic [3:0]  exp_flags;
    } vec_t;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    ex_unit_mc_if #(.DATA_W(32)) bus ();

    ex_unit_mc #(
        .DATA_W   (32),
        .MUL_STEP (2)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Present one op at the falling edge, accept on the next rising edge.
    task automatic issue(input vec_t v);
        @(negedge clk);
        bus.op      = v.op;
        bus.src_a   = v.a;
        bus.src_b   = v.b;
        bus.imm     = v.imm;
        bus.imm_sel = v.imm_sel;
        bus.sh_amt  = v.sh;
        bus.psr_wen = v.wen;
        bus.dest    = v.dest;
        bus.in_valid = 1'b1;
        #1;
        check("issue_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    vec_t vecs[15];
    vec_t v;

    initial begin
        int cyc;
        int bad;
        int saw;
        n_pass  = 0;
        n_total = 0;

        //            op      a             b             imm           isel sh wen dest  exp_data      wr  flags NZCV
        vecs[0]  = '{OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h0,        0, 5'd0, 1, 3'd1, 32'h00000000, 1, 4'b0110};
        vecs[1]  = '{OP_SUB, 32'h80000000, 32'h00000001, 32'h0,        0, 5'd0, 1, 3'd2, 32'h7FFFFFFF, 1, 4'b0011};
        vecs[2]  = '{OP_CMP, 32'h80000000, 32'h00000001, 32'h0,        0, 5'd0, 1, 3'd3, 32'h7FFFFFFF, 0, 4'b0011};
        vecs[3]  = '{OP_AND, 32'hF0F0F0F0, 32'hFFFFFFFF, 32'h0F0F0F0F, 1, 5'd0, 1, 3'd4, 32'h00000000, 1, 4'b0111};
        vecs[4]  = '{OP_OR,  32'h80000000, 32'h00000001, 32'h0,        0, 5'd0, 1, 3'd5, 32'h80000001, 1, 4'b1011};
        vecs[5]  = '{OP_XOR, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h0,        0, 5'd0, 0, 3'd6, 32'h00000000, 1, 4'b1011};
        vecs[6]  = '{OP_MOV, 32'h0,        32'h12345678, 32'h0,        0, 5'd0, 1, 3'd7, 32'h12345678, 1, 4'b0011};
        vecs[7]  = '{OP_LSL, 32'h80000001, 32'h0,        32'h0,        0, 5'd1, 1, 3'd0, 32'h00000002, 1, 4'b0011};
        vecs[8]  = '{OP_ASR, 32'h80000000, 32'h0,        32'h0,        0, 5'd4, 1, 3'd1, 32'hF8000000, 1, 4'b1001};
        vecs[9]  = '{OP_ADD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        0, 5'd0, 1, 3'd2, 32'hFFFFFFFE, 1, 4'b1010};
        vecs[10] = '{OP_LSR, 32'h12345678, 32'h0,        32'h0,        0, 5'd0, 1, 3'd3, 32'h12345678, 1, 4'b0010};
        vecs[11] = '{OP_ROR, 32'h00000001, 32'h0,        32'h0,        0, 5'd1, 1, 3'd4, 32'h80000000, 1, 4'b1010};
        vecs[12] = '{OP_LSR, 32'h00000003, 32'h0,        32'h0,        0, 5'd1, 1, 3'd5, 32'h00000001, 1, 4'b0010};
        vecs[13] = '{4'hF,   32'h0,        32'hDEADBEEF, 32'h0,        0, 5'd0, 1, 3'd6, 32'hDEADBEEF, 0, 4'b0010};
        vecs[14] = '{OP_SUB, 32'h00000005, 32'h00000005, 32'h0,        0, 5'd0, 1, 3'd7, 32'h00000000, 1, 4'b0110};

        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.src_a     = '0;
        bus.src_b     = '0;
        bus.imm       = '0;
        bus.imm_sel   = 1'b0;
        bus.sh_amt    = '0;
        bus.psr_wen   = 1'b0;
        bus.dest      = '0;
        bus.out_ready = 1'b1;
        reset         = 1'b1;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_data",  bus.out_data, 32'd0);
        check("rst_out_dest",  {29'd0, bus.out_dest}, 32'd0);
        check("rst_out_wr",    {31'd0, bus.out_wr}, 32'd0);
        check("rst_flags",     {28'd0, bus.psr_flags}, 32'd0);
        check("rst_busy",      {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // ---------------- single-cycle op table ----------------
        for (int i = 0; i < 15; i++) begin
            issue(vecs[i]);
            check($sformatf("v%0d_valid", i), {31'd0, bus.out_valid}, 32'd1);
            check($sformatf("v%0d_data", i),  bus.out_data, vecs[i].exp_data);
            check($sformatf("v%0d_wr", i),    {31'd0, bus.out_wr}, {31'd0, vecs[i].exp_wr});
            check($sformatf("v%0d_dest", i),  {29'd0, bus.out_dest}, {29'd0, vecs[i].dest});
            check($sformatf("v%0d_flags", i), {28'd0, bus.psr_flags}, {28'd0, vecs[i].exp_flags});
        end

        // ---------------- multiply latency + output stall ----------------
        v = '{OP_MUL, 32'h00010003, 32'h00000005, 32'h0, 0, 5'd0, 1, 3'd6, 32'h0005000F, 1, 4'b0010};
        issue(v);
        bus.out_ready = 1'b0;
        check("mul_busy_start",  {31'd0, bus.busy}, 32'd1);
        check("mul_valid_start", {31'd0, bus.out_valid}, 32'd0);
        cyc = 0;
        bad = 0;
        while (bus.out_valid !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.out_valid !== 1'b1 && (bus.busy !== 1'b1 || bus.in_ready !== 1'b0)) bad++;
        end
        check("mul_latency",        cyc, 32'd17);
        check("mul_busy_ready_bad", bad, 32'd0);
        check("mul_data",  bus.out_data, 32'h0005000F);
        check("mul_dest",  {29'd0, bus.out_dest}, 32'd6);
        check("mul_wr",    {31'd0, bus.out_wr}, 32'd1);
        check("mul_flags", {28'd0, bus.psr_flags}, 32'b0010);
        check("mul_busy_end", {31'd0, bus.busy}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("stall_valid",    {31'd0, bus.out_valid}, 32'd1);
            check("stall_data",     bus.out_data, 32'h0005000F);
            check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        v = '{OP_ADD, 32'h00000002, 32'h00000003, 32'h0, 0, 5'd0, 0, 3'd5, 32'h00000005, 1, 4'b0010};
        issue(v);
        check("b2b_valid", {31'd0, bus.out_valid}, 32'd1);
        check("b2b_data",  bus.out_data, 32'h00000005);
        check("b2b_dest",  {29'd0, bus.out_dest}, 32'd5);
        check("b2b_flags", {28'd0, bus.psr_flags}, 32'b0010);
        @(posedge clk);
        #1;
        check("drain_valid", {31'd0, bus.out_valid}, 32'd0);

        // ---------------- reset during multiply ----------------
        v = '{OP_MUL, 32'h00000007, 32'h00000009, 32'h0, 0, 5'd0, 1, 3'd3, 32'h0000003F, 1, 4'b0000};
        issue(v);
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_valid", {31'd0, bus.out_valid}, 32'd0);
        check("abort_flags", {28'd0, bus.psr_flags}, 32'd0);
        check("abort_busy",  {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
        saw = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) saw++;
        end
        check("abort_no_stale", saw, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
